// File: rtl/som_pkg.sv
// Shared SOM definitions: grid geometry, coordinate field helpers and the
// scheduler FSM encoding. Used by the comparator tree and the weight-update path.
package som_pkg;

    localparam int GRID_DIM = 4;
    localparam int COORD_W  = 4;
    localparam int RAD_W    = 2;
    localparam int DIST_W   = 3;
    localparam int ROW_W    = COORD_W / 2;

    localparam logic [COORD_W-1:0] LAST_IDX = COORD_W'(GRID_DIM * GRID_DIM - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FINISH = 2'd2
    } sched_state_t;

    // Upper half of a coordinate is the row, lower half the column.
    function automatic logic [ROW_W-1:0] coord_row(input logic [COORD_W-1:0] c);
        return c[COORD_W-1:ROW_W];
    endfunction

    function automatic logic [ROW_W-1:0] coord_col(input logic [COORD_W-1:0] c);
        return c[ROW_W-1:0];
    endfunction

endpackage

// File: rtl/som_manhattan_dist.sv
// Combinational Manhattan distance between two grid coordinates.
// Differences are taken as magnitudes so the sum never wraps.
module som_manhattan_dist
    import som_pkg::*;
(
    input  logic [COORD_W-1:0] i_coord_a,
    input  logic [COORD_W-1:0] i_coord_b,
    output logic [DIST_W-1:0]  o_dist
);

    logic [ROW_W-1:0] w_row_a;
    logic [ROW_W-1:0] w_row_b;
    logic [ROW_W-1:0] w_col_a;
    logic [ROW_W-1:0] w_col_b;
    logic [ROW_W-1:0] w_dr;
    logic [ROW_W-1:0] w_dc;

    assign w_row_a = coord_row(i_coord_a);
    assign w_row_b = coord_row(i_coord_b);
    assign w_col_a = coord_col(i_coord_a);
    assign w_col_b = coord_col(i_coord_b);

    assign w_dr = (w_row_a > w_row_b) ? (w_row_a - w_row_b) : (w_row_b - w_row_a);
    assign w_dc = (w_col_a > w_col_b) ? (w_col_a - w_col_b) : (w_col_b - w_col_a);

    assign o_dist = DIST_W'(w_dr) + DIST_W'(w_dc);

endmodule

// File: rtl/som_neighbor_scheduler.sv
// Scans the 4x4 SOM grid after a winner search and issues one update request
// per neuron within the radius. Macro SOM_NBR_SHIFT_EN enables per-hop rate shift.
module som_neighbor_scheduler
    import som_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] winner_coordinate,
    input  logic [RAD_W-1:0]   radius,
    output logic               upd_valid,
    input  logic               upd_ready,
    output logic [COORD_W-1:0] upd_coordinate,
    output logic [DIST_W-1:0]  upd_shift,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    sched_state_t       r_state;
    sched_state_t       w_next_state;
    logic [COORD_W-1:0] r_idx;
    logic [COORD_W-1:0] w_next_idx;
    logic [COORD_W-1:0] r_win;
    logic [RAD_W-1:0]   r_rad;
    logic [DIST_W-1:0]  w_dist;
    logic               w_in_range;
    logic               w_advance;

    som_manhattan_dist u_dist (
        .i_coord_a (r_idx),
        .i_coord_b (r_win),
        .o_dist    (w_dist)
    );

    assign w_in_range = (w_dist <= DIST_W'(r_rad));

    // Handshake: a request is transferred on a cycle with upd_valid && upd_ready;
    // while valid and not ready, coordinate and shift hold because r_idx holds.
    // Out-of-range neurons are skipped in a single cycle with upd_valid low.
    assign w_advance = (r_state == ST_SCAN) && (!w_in_range || upd_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_win   <= '0;
            r_rad   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            if (r_state == ST_IDLE && start) begin
                r_win <= winner_coordinate;
                r_rad <= radius;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_SCAN;
                    w_next_idx   = '0;
                end
            end
            ST_SCAN: begin
                if (w_advance) begin
                    w_next_idx = r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_next_state = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs decode the registered state/index only; idle outputs are all zero.
    always_comb begin
        upd_valid      = 1'b0;
        upd_coordinate = '0;
        upd_shift      = '0;
        busy           = (r_state != ST_IDLE);
        done           = (r_state == ST_FINISH);
        if (r_state == ST_SCAN) begin
            upd_valid      = w_in_range;
            upd_coordinate = r_idx;
`ifdef SOM_NBR_SHIFT_EN
            upd_shift      = w_in_range ? w_dist : '0;
`else
            upd_shift      = '0;
`endif
        end
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_som_neighbor_scheduler.sv
// Directed bench for som_neighbor_scheduler; expected request lists are hand-computed.
// Outputs are sampled and inputs driven on the falling edge.
module tb_som_neighbor_scheduler;

`ifdef SOM_NBR_SHIFT_EN
    localparam bit SHIFT_ON = 1'b1;
`else
    localparam bit SHIFT_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] winner_coordinate;
    logic [1:0] radius;
    logic       upd_valid;
    logic       upd_ready;
    logic [3:0] upd_coordinate;
    logic [2:0] upd_shift;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] exp_q[$];

    som_neighbor_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .winner_coordinate (winner_coordinate),
        .radius            (radius),
        .upd_valid         (upd_valid),
        .upd_ready         (upd_ready),
        .upd_coordinate    (upd_coordinate),
        .upd_shift         (upd_shift),
        .busy              (busy),
        .done              (done),
        .dbg_state         (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [2:0] d);
        exp_q.push_back({c, (SHIFT_ON ? d : 3'd0)});
    endtask

    // Called on a falling edge; returns on the falling edge of SCAN cycle 1.
    task automatic kick(input logic [3:0] w, input logic [1:0] r);
        start             = 1'b1;
        winner_coordinate = w;
        radius            = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consumes requests until done; cycle 1 is the first SCAN cycle.
    task automatic run_scan(input bit toggle, input bit poke_start,
                            output int done_cyc, output int busy_cnt);
        int         c;
        int         n_acc;
        int         n_exp;
        logic       held;
        logic [3:0] hc;
        logic [2:0] hs;
        logic [6:0] e;
        done_cyc = -1;
        busy_cnt = 0;
        n_acc    = 0;
        n_exp    = exp_q.size();
        held     = 1'b0;
        hc       = '0;
        hs       = '0;
        c        = 1;
        while (done_cyc < 0 && c <= 100) begin
            upd_ready = toggle ? c[0] : 1'b1;
            if (poke_start) begin
                start = (c == 3);
                if (c == 3) begin
                    winner_coordinate = 4'd10;
                    radius            = 2'd3;
                end
            end
            if (busy === 1'b1) busy_cnt++;
            if (held) begin
                check("hold_valid", upd_valid, 1);
                check("hold_coord", upd_coordinate, hc);
                check("hold_shift", upd_shift, hs);
            end
            if (upd_valid === 1'b1 && upd_ready) begin
                n_acc++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("req_coord", upd_coordinate, e[6:3]);
                    check("req_shift", upd_shift, e[2:0]);
                end
                held = 1'b0;
            end else if (upd_valid === 1'b1) begin
                held = 1'b1;
                hc   = upd_coordinate;
                hs   = upd_shift;
            end else begin
                held = 1'b0;
            end
            if (done === 1'b1) begin
                done_cyc = c;
                check("done_state", dbg_state, 2);
            end
            @(negedge clk);
            c++;
        end
        start     = 1'b0;
        upd_ready = 1'b1;
        if (done_cyc < 0) check("done_timeout", 0, 1);
        check("req_count", n_acc, n_exp);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        exp_q.delete();
    endtask

    initial begin
        int dc;
        int bc;
        rst               = 1'b1;
        start             = 1'b0;
        winner_coordinate = '0;
        radius            = '0;
        upd_ready         = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_valid", upd_valid, 0);
        check("rst_coord", upd_coordinate, 0);
        check("rst_shift", upd_shift, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        @(negedge clk);

        // Winner (1,1), radius 1: the plus-shaped neighbourhood.
        push(4'd1, 3'd1); push(4'd4, 3'd1); push(4'd5, 3'd0);
        push(4'd6, 3'd1); push(4'd9, 3'd1);
        kick(4'd5, 2'd1);
        run_scan(1'b0, 1'b0, dc, bc);
        check("t1_done_cycle", dc, 17);
        check("t1_busy_cycles", bc, 17);

        // Corner winner, radius 0: only the winner.
        push(4'd0, 3'd0);
        kick(4'd0, 2'd0);
        run_scan(1'b0, 1'b0, dc, bc);
        check("t2_done_cycle", dc, 17);
        check("t2_busy_cycles", bc, 17);

        // Opposite corner, radius 3, with ready toggling each cycle.
        push(4'd3,  3'd3);
        push(4'd6,  3'd3); push(4'd7,  3'd2);
        push(4'd9,  3'd3); push(4'd10, 3'd2); push(4'd11, 3'd1);
        push(4'd12, 3'd3); push(4'd13, 3'd2); push(4'd14, 3'd1); push(4'd15, 3'd0);
        kick(4'd15, 2'd3);
        run_scan(1'b1, 1'b0, dc, bc);
        check("t3_done_seen", (dc > 17), 1);

        // start pulsed mid-scan with a different winner must be ignored.
        push(4'd1, 3'd1); push(4'd4, 3'd1); push(4'd5, 3'd0);
        push(4'd6, 3'd1); push(4'd9, 3'd1);
        kick(4'd5, 2'd1);
        run_scan(1'b0, 1'b1, dc, bc);
        check("t4_done_cycle", dc, 17);

        // Reset during the fifth SCAN cycle.
        kick(4'd0, 2'd3);
        repeat (4) @(negedge clk);
        check("t5_pre_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_valid", upd_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_coord", upd_coordinate, 0);
        check("t5_state", dbg_state, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fresh scan after reset: winner (1,1), radius 2.
        push(4'd0, 3'd2); push(4'd1, 3'd1); push(4'd2, 3'd2);
        push(4'd4, 3'd1); push(4'd5, 3'd0); push(4'd6, 3'd1); push(4'd7, 3'd2);
        push(4'd8, 3'd2); push(4'd9, 3'd1); push(4'd10, 3'd2);
        push(4'd13, 3'd2);
        kick(4'd5, 2'd2);
        run_scan(1'b0, 1'b0, dc, bc);
        check("t6_done_cycle", dc, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
